// File: rtl/sv_types_pkg.sv
// sv_types_pkg: shared types for the ALU command issuer.
//   opcode_t       - 2-bit ALU opcode (ADD/SUB/AND/OR)
//   issuer_state_t - issuer FSM states
//   alu_cmd_t      - default-width command record {op, a, b}
package sv_types_pkg;

    localparam int unsigned W_DEF = 8;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_AND = 2'd2,
        OP_OR  = 2'd3
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } issuer_state_t;

    // Default-width command record; the issuer builds its own record of the
    // same layout sized by its W parameter.
    typedef struct packed {
        opcode_t          op;
        logic [W_DEF-1:0] a;
        logic [W_DEF-1:0] b;
    } alu_cmd_t;

endpackage

// File: rtl/sv_cmd_fifo.sv
// sv_cmd_fifo: synchronous FIFO holding issuer commands, no write-to-read bypass.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   push, push_data     - write request (ignored when full) and entry
//   pop, pop_data       - read request (ignored when empty) and head entry
//   full, empty         - occupancy status
module sv_cmd_fifo
    import sv_types_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type         T     = alu_cmd_t
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  T     push_data,
    input  logic pop,
    output T     pop_data,
    output logic full,
    output logic empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    T              mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q];

    // Storage needs no reset: entries are only visible through count_q.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/sv_alu_issuer.sv
// sv_alu_issuer: in-order command front end for a 4-op combinational ALU.
// Commands are queued in sv_cmd_fifo, issued one at a time onto alu_op/a/b,
// and the ALU result is returned over a valid/ready response handshake.
// Ports:
//   clk, rst                           - clock, synchronous active-high reset
//   cmd_valid/cmd_ready/cmd_op/a/b     - command handshake (cmd_ready = not full)
//   alu_op/alu_a/alu_b, alu_res        - registered ALU drive, combinational result
//   rsp_valid/rsp_ready/rsp_res/rsp_op - response handshake
//   busy                               - FSM not idle or commands queued
//   rsp_flags {zero, neg}              - only when SV_ALU_ISSUER_FLAGS_EN is defined
module sv_alu_issuer
    import sv_types_pkg::*;
#(
    parameter int unsigned W     = W_DEF,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [W-1:0] cmd_a,
    input  logic [W-1:0] cmd_b,
    output logic [1:0]   alu_op,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    input  logic [W-1:0] alu_res,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_res,
    output logic [1:0]   rsp_op,
    output logic         busy
`ifdef SV_ALU_ISSUER_FLAGS_EN
    ,
    output logic [1:0]   rsp_flags
`endif
);

    typedef struct packed {
        opcode_t      op;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } cmd_t;

    cmd_t          push_data;
    cmd_t          pop_data;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;

    issuer_state_t state_q, state_d;
    opcode_t       alu_op_q;
    logic [W-1:0]  alu_a_q;
    logic [W-1:0]  alu_b_q;
    logic          rsp_valid_q;
    logic [W-1:0]  rsp_res_q;
    opcode_t       rsp_op_q;

    always_comb begin
        push_data    = '0;
        push_data.op = opcode_t'(cmd_op);
        push_data.a  = cmd_a;
        push_data.b  = cmd_b;
    end

    sv_cmd_fifo #(
        .DEPTH (DEPTH),
        .T     (cmd_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cmd_valid),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (pop_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Next-state and pop decode.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: state_d = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            alu_op_q    <= OP_ADD;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_res_q   <= '0;
            rsp_op_q    <= OP_ADD;
        end else begin
            state_q <= state_d;
            // ALU operands only move on a pop; they hold between commands.
            if (pop) begin
                alu_op_q <= pop_data.op;
                alu_a_q  <= pop_data.a;
                alu_b_q  <= pop_data.b;
            end
            if (state_q == EXEC) begin
                rsp_valid_q <= 1'b1;
                rsp_res_q   <= alu_res;
                rsp_op_q    <= alu_op_q;
            end else if (state_q == RESP && rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

`ifdef SV_ALU_ISSUER_FLAGS_EN
    logic [1:0] rsp_flags_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_flags_q <= 2'b00;
        end else if (state_q == EXEC) begin
            rsp_flags_q <= {(alu_res == '0), alu_res[W-1]};
        end
    end

    assign rsp_flags = rsp_flags_q;
`endif

    assign cmd_ready = !fifo_full;
    assign alu_op    = alu_op_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_res   = rsp_res_q;
    assign rsp_op    = rsp_op_q;
    assign busy      = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_sv_alu_issuer.sv
// tb_sv_alu_issuer: self-checking bench for sv_alu_issuer. Directed vector
// table, hand-written multi-cycle sequences, and randomized traffic checked by
// an in-order scoreboard fed from the command handshake.
module tb_sv_alu_issuer;

    localparam int unsigned W     = 8;
    localparam int unsigned DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [W-1:0] cmd_a;
    logic [W-1:0] cmd_b;
    logic [1:0]   alu_op;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [W-1:0] alu_res;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_res;
    logic [1:0]   rsp_op;
    logic         busy;
`ifdef SV_ALU_ISSUER_FLAGS_EN
    logic [1:0]   rsp_flags;
`endif

    sv_alu_issuer #(
        .W     (W),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .alu_op    (alu_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_res   (alu_res),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_res   (rsp_res),
        .rsp_op    (rsp_op),
        .busy      (busy)
`ifdef SV_ALU_ISSUER_FLAGS_EN
        ,
        .rsp_flags (rsp_flags)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural 4-op ALU attached to the issuer.
    always_comb begin
        case (alu_op)
            2'd0:    alu_res = alu_a + alu_b;
            2'd1:    alu_res = alu_a - alu_b;
            2'd2:    alu_res = alu_a & alu_b;
            default: alu_res = alu_a | alu_b;
        endcase
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference result from plain integer arithmetic modulo 2^W.
    function automatic logic [W-1:0] ref_alu(input logic [1:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        int unsigned ia = a;
        int unsigned ib = b;
        int unsigned m  = 1 << W;
        int unsigned r;
        case (op)
            2'd0:    r = (ia + ib) % m;
            2'd1:    r = (ia + m - ib) % m;
            2'd2:    r = ia & ib;
            default: r = ia | ib;
        endcase
        return W'(r);
    endfunction

    typedef struct packed {
        logic [1:0]   op;
        logic [W-1:0] res;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         mon_e;
    int           rsp_count = 0;
    logic         prev_hold = 1'b0;
    logic [W-1:0] prev_res;
    logic [1:0]   prev_op;

    // Scoreboard: sampled on the falling edge, where inputs and outputs are settled and
    // describe the handshakes that take effect at the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("rsp_hold_valid", rsp_valid, 1);
                check("rsp_hold_res", rsp_res, prev_res);
                check("rsp_hold_op", rsp_op, prev_op);
            end
            if (cmd_valid && cmd_ready) begin
                mon_e.op  = cmd_op;
                mon_e.res = ref_alu(cmd_op, cmd_a, cmd_b);
                exp_q.push_back(mon_e);
            end
            if (rsp_valid && rsp_ready) begin
                rsp_count++;
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", rsp_valid, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("sb_res", rsp_res, mon_e.res);
                    check("sb_op", rsp_op, mon_e.op);
`ifdef SV_ALU_ISSUER_FLAGS_EN
                    check("sb_flags", rsp_flags, {(mon_e.res == '0), mon_e.res[W-1]});
`endif
                end
            end
            prev_hold = rsp_valid && !rsp_ready;
            prev_res  = rsp_res;
            prev_op   = rsp_op;
        end
    end

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic [1:0]   flags;
    } vec_t;

    vec_t         vecs[7];
    int           cyc;
    int           accepted;
    int           n;
    int           t_seen[2];
    logic [W-1:0] r_seen[2];
    logic         acc_now;
    int           cnt_before;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_cmd();
        cmd_op = 2'($urandom_range(0, 3));
        cmd_a  = W'($urandom);
        cmd_b  = W'($urandom);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{2'd0, 8'h05, 8'h03, 8'h08, 2'b00};
        vecs[1] = '{2'd1, 8'h03, 8'h05, 8'hFE, 2'b01};
        vecs[2] = '{2'd2, 8'hF0, 8'h3C, 8'h30, 2'b00};
        vecs[3] = '{2'd3, 8'hF0, 8'h0F, 8'hFF, 2'b01};
        vecs[4] = '{2'd1, 8'h7A, 8'h7A, 8'h00, 2'b10};
        vecs[5] = '{2'd0, 8'hFF, 8'h01, 8'h00, 2'b10};
        vecs[6] = '{2'd0, 8'h7F, 8'h01, 8'h80, 2'b01};

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_a     = '0;
        cmd_b     = '0;
        rsp_ready = 1'b0;
        tick();
        tick();

        check("reset_cmd_ready", cmd_ready, 1);
        check("reset_alu_op", alu_op, 0);
        check("reset_alu_a", alu_a, 0);
        check("reset_alu_b", alu_b, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_res", rsp_res, 0);
        check("reset_rsp_op", rsp_op, 0);
        check("reset_busy", busy, 0);
`ifdef SV_ALU_ISSUER_FLAGS_EN
        check("reset_rsp_flags", rsp_flags, 0);
`endif
        rst = 1'b0;
        tick();

        // Directed single commands: result, opcode, flags and 2-cycle latency.
        rsp_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            cmd_op    = vecs[i].op;
            cmd_a     = vecs[i].a;
            cmd_b     = vecs[i].b;
            cmd_valid = 1'b1;
            tick();
            cmd_valid = 1'b0;
            cyc = 0;
            while (!rsp_valid && cyc < 20) begin
                tick();
                cyc++;
            end
            check($sformatf("vec%0d_latency", i), cyc, 2);
            check($sformatf("vec%0d_res", i), rsp_res, vecs[i].res);
            check($sformatf("vec%0d_op", i), rsp_op, vecs[i].op);
`ifdef SV_ALU_ISSUER_FLAGS_EN
            check($sformatf("vec%0d_flags", i), rsp_flags, vecs[i].flags);
`endif
            tick();
            tick();
        end

        // Back-to-back AND then OR: in order, three cycles apart.
        cmd_valid = 1'b1;
        cmd_op = 2'd2; cmd_a = 8'hF0; cmd_b = 8'h3C;
        tick();
        cmd_op = 2'd3; cmd_a = 8'hF0; cmd_b = 8'h0F;
        tick();
        cmd_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 20 && n < 2; i++) begin
            tick();
            if (rsp_valid) begin
                t_seen[n] = i;
                r_seen[n] = rsp_res;
                n++;
            end
        end
        check("b2b_count", n, 2);
        if (n == 2) begin
            check("b2b_first", r_seen[0], 8'h30);
            check("b2b_second", r_seen[1], 8'hFF);
            check("b2b_spacing", t_seen[1] - t_seen[0], 3);
        end
        tick();
        tick();

        // Backpressure: DEPTH+1 commands fit (one in flight plus a full FIFO).
        rsp_ready  = 1'b0;
        cnt_before = rsp_count;
        rand_cmd();
        cmd_valid = 1'b1;
        accepted  = 0;
        for (int i = 0; i < 12; i++) begin
            acc_now = cmd_ready;
            tick();
            if (acc_now) begin
                accepted++;
                rand_cmd();
            end
        end
        cmd_valid = 1'b0;
        check("bp_accepted", accepted, DEPTH + 1);
        check("bp_cmd_ready_low", cmd_ready, 0);
        check("bp_rsp_valid", rsp_valid, 1);
        check("bp_busy", busy, 1);
        rsp_ready = 1'b1;
        cyc = 0;
        while (busy && cyc < 40) begin
            tick();
            cyc++;
        end
        check("bp_drain_busy", busy, 0);
        check("bp_drain_count", rsp_count - cnt_before, DEPTH + 1);
        check("bp_queue_empty", exp_q.size(), 0);
        tick();

        // Reset while in RESP with three commands queued.
        rsp_ready = 1'b0;
        cmd_valid = 1'b1;
        rand_cmd();
        accepted = 0;
        for (int i = 0; i < 12 && accepted < 4; i++) begin
            acc_now = cmd_ready;
            tick();
            if (acc_now) begin
                accepted++;
                rand_cmd();
                cmd_a = cmd_a | 8'h01;
            end
        end
        cmd_valid = 1'b0;
        tick();
        tick();
        check("rst_mid_pre_valid", rsp_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_rsp_valid", rsp_valid, 0);
        check("rst_mid_cmd_ready", cmd_ready, 1);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_alu_op", alu_op, 0);
        check("rst_mid_alu_a", alu_a, 0);
        check("rst_mid_alu_b", alu_b, 0);
        rsp_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (rsp_valid) n++;
        end
        check("rst_mid_no_stale", n, 0);

        // Randomized traffic against the scoreboard.
        for (int i = 0; i < 400; i++) begin
            cmd_valid = ($urandom_range(0, 2) != 0);
            rand_cmd();
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        cyc = 0;
        while (busy && cyc < 60) begin
            tick();
            cyc++;
        end
        check("rand_drain_busy", busy, 0);
        check("rand_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
